// File: rtl/matrix_display_scheduler.sv
// Column strobe sequencer for the 8x4 LED matrix. It also shares the single seven-segment path
// among four requesters: round-robin with a minimum hold, switching only at frame boundaries.
module matrix_display_scheduler #(
  parameter int unsigned STROBE_DIV   = 8192,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned HOLD_FRAMES  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] seg_in,
  output logic [3:0]  grant,
  output logic [7:0]  seg_out,
  output logic [3:0]  col_strobe,
  output logic [1:0]  col_idx,
  output logic        blank,
  output logic        frame_start
);

  localparam int unsigned CntW  = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
  localparam int unsigned HoldW = $clog2(HOLD_FRAMES + 1);
  localparam logic [CntW-1:0]  CntMax   = CntW'(STROBE_DIV - 1);
  localparam logic [CntW-1:0]  BlankLim = CntW'(BLANK_CYCLES);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(HOLD_FRAMES - 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic             first_q;
  logic             frame_start_q;
  logic [3:0]       grant_q, grant_d;
  logic [7:0]       seg_out_q, seg_out_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;

  logic       cnt_wrap;
  logic       frame_end;
  logic       owner_valid;
  logic [1:0] owner_idx;
  logic       others_req;
  logic       keep_owner;
  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;

  // Column sequencer
  always_comb begin
    cnt_wrap  = (cnt_q == CntMax);
    cnt_d     = cnt_wrap ? '0 : cnt_q + 1'b1;
    col_idx_d = cnt_wrap ? col_idx_q + 2'd1 : col_idx_q;
    frame_end = first_q | (cnt_wrap & (col_idx_q == 2'd3));
  end

  // Decode current owner and round-robin candidate
  always_comb begin
    owner_valid = 1'b1;
    owner_idx   = 2'd0;
    unique case (grant_q)
      4'b0001: owner_idx = 2'd0;
      4'b0010: owner_idx = 2'd1;
      4'b0100: owner_idx = 2'd2;
      4'b1000: owner_idx = 2'd3;
      default: owner_valid = 1'b0;
    endcase
    others_req = |(req & ~grant_q);
    keep_owner = owner_valid & req[owner_idx] & ((hold_cnt_q < HoldMax) | ~others_req);

    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    // Scan rr_ptr+1 .. rr_ptr+4; the last candidate wraps back to rr_ptr itself
    for (int i = 1; i <= 4; i++) begin
      cand = rr_ptr_q + 2'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Arbitration; all ownership state is frozen between frame boundaries
  always_comb begin
    grant_d    = grant_q;
    seg_out_d  = seg_out_q;
    hold_cnt_d = hold_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    if (frame_end) begin
      if (keep_owner) begin
        seg_out_d  = seg_in[{owner_idx, 3'b000} +: 8];
        hold_cnt_d = (hold_cnt_q < HoldMax) ? hold_cnt_q + 1'b1 : hold_cnt_q;
      end else if (win_found) begin
        grant_d    = 4'b0001 << win_idx;
        seg_out_d  = seg_in[{win_idx, 3'b000} +: 8];
        rr_ptr_d   = win_idx;
        hold_cnt_d = '0;
      end else begin
        grant_d    = 4'b0000;
        seg_out_d  = 8'hFF;
        hold_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      col_idx_q     <= 2'd0;
      first_q       <= 1'b1;
      frame_start_q <= 1'b0;
      grant_q       <= 4'b0000;
      seg_out_q     <= 8'hFF;
      hold_cnt_q    <= '0;
      rr_ptr_q      <= 2'd3;
    end else begin
      cnt_q         <= cnt_d;
      col_idx_q     <= col_idx_d;
      first_q       <= 1'b0;
      frame_start_q <= frame_end;
      grant_q       <= grant_d;
      seg_out_q     <= seg_out_d;
      hold_cnt_q    <= hold_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  always_comb begin
    blank       = (cnt_q < BlankLim);
    col_strobe  = blank ? 4'b0000 : (4'b0001 << col_idx_q);
    col_idx     = col_idx_q;
    grant       = grant_q;
    seg_out     = seg_out_q;
    frame_start = frame_start_q;
  end

endmodule

// File: tb/tb_matrix_display_scheduler.sv
// Directed bench for matrix_display_scheduler with a short strobe period (8 cycles, 2 blank,
// hold of 2 frames). A frame is 32 cycles; cycle numbers count from reset release.
module tb_matrix_display_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] seg_in = 32'hFFFF_FFFF;
  logic [3:0]  grant;
  logic [7:0]  seg_out;
  logic [3:0]  col_strobe;
  logic [1:0]  col_idx;
  logic        blank;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  matrix_display_scheduler #(
    .STROBE_DIV  (8),
    .BLANK_CYCLES(2),
    .HOLD_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .seg_in     (seg_in),
    .grant      (grant),
    .seg_out    (seg_out),
    .col_strobe (col_strobe),
    .col_idx    (col_idx),
    .blank      (blank),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  // Release lands mid-cycle; that partial cycle is cycle 0
  task automatic do_reset(input logic [3:0] r, input logic [31:0] s);
    rst_n  = 1'b0;
    req    = r;
    seg_in = s;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  logic [3:0] exp_g [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                            4'b1000, 4'b1000, 4'b0001};
  logic [7:0] exp_s [9] = '{8'hA0, 8'hA0, 8'hA1, 8'hA1, 8'hA2, 8'hA2, 8'hA3, 8'hA3, 8'hA0};

  initial begin
    logic [3:0] es;
    logic       ef;

    // 1: idle sequencing with no requests
    do_reset(4'b0000, 32'hFFFF_FFFF);
    chk("t1 reset blank", {31'd0, blank}, 32'd1);
    for (int c = 0; c <= 70; c++) begin
      run_to(c);
      es = ((c % 8) < 2) ? 4'b0000 : (4'b0001 << ((c / 8) % 4));
      ef = (c == 1) || (c != 0 && (c % 32) == 0);
      chk($sformatf("t1 strobe c%0d", c), {28'd0, col_strobe}, {28'd0, es});
      chk($sformatf("t1 col_idx c%0d", c), {30'd0, col_idx}, 32'((c / 8) % 4));
      chk($sformatf("t1 frame_start c%0d", c), {31'd0, frame_start}, {31'd0, ef});
      chk($sformatf("t1 grant c%0d", c), {28'd0, grant}, 32'h0);
      chk($sformatf("t1 seg_out c%0d", c), {24'd0, seg_out}, 32'hFF);
    end

    // 2: single requester wins at the first boundary and keeps the display
    do_reset(4'b0001, 32'hFFFF_FFC0);
    chk("t2 grant c0", {28'd0, grant}, 32'h0);
    chk("t2 seg c0", {24'd0, seg_out}, 32'hFF);
    run_to(1);
    chk("t2 grant c1", {28'd0, grant}, 32'h1);
    chk("t2 seg c1", {24'd0, seg_out}, 32'hC0);
    chk("t2 fs c1", {31'd0, frame_start}, 32'd1);
    run_to(40);
    chk("t2 grant c40", {28'd0, grant}, 32'h1);
    run_to(100);
    chk("t2 grant c100", {28'd0, grant}, 32'h1);
    chk("t2 seg c100", {24'd0, seg_out}, 32'hC0);

    // 4: mid-frame byte change only appears at the next boundary
    run_to(138);
    seg_in = 32'hFFA2_FFF9;
    run_to(139);
    chk("t4 seg c139", {24'd0, seg_out}, 32'hC0);
    run_to(159);
    chk("t4 seg c159", {24'd0, seg_out}, 32'hC0);
    run_to(160);
    chk("t4 seg c160", {24'd0, seg_out}, 32'hF9);
    chk("t4 fs c160", {31'd0, frame_start}, 32'd1);

    // 5: owner drops mid-frame; handover waits for the boundary
    run_to(165);
    req = 4'b0100;
    run_to(191);
    chk("t5 grant c191", {28'd0, grant}, 32'h1);
    chk("t5 seg c191", {24'd0, seg_out}, 32'hF9);
    run_to(192);
    chk("t5 grant c192", {28'd0, grant}, 32'h4);
    chk("t5 seg c192", {24'd0, seg_out}, 32'hA2);

    // 3: all four requesting rotate every HOLD_FRAMES frames
    do_reset(4'b1111, 32'hA3A2_A1A0);
    for (int k = 0; k <= 8; k++) begin
      run_to((k == 0) ? 1 : 32 * k);
      chk($sformatf("t3 grant f%0d", k), {28'd0, grant}, {28'd0, exp_g[k]});
      chk($sformatf("t3 seg f%0d", k), {24'd0, seg_out}, {24'd0, exp_s[k]});
      chk($sformatf("t3 fs f%0d", k), {31'd0, frame_start}, 32'd1);
    end

    // 6: asynchronous reset mid-frame, then restart with round-robin from rr_ptr=3
    do_reset(4'b0010, 32'hFFFF_B1FF);
    run_to(1);
    chk("t6 grant c1", {28'd0, grant}, 32'h2);
    run_to(49);
    rst_n = 1'b0;
    #1;
    chk("t6 rst grant", {28'd0, grant}, 32'h0);
    chk("t6 rst seg", {24'd0, seg_out}, 32'hFF);
    chk("t6 rst strobe", {28'd0, col_strobe}, 32'h0);
    chk("t6 rst col_idx", {30'd0, col_idx}, 32'h0);
    chk("t6 rst blank", {31'd0, blank}, 32'd1);
    do_reset(4'b1010, 32'hB3FF_B1FF);
    run_to(1);
    chk("t6 grant after", {28'd0, grant}, 32'h2);
    chk("t6 seg after", {24'd0, seg_out}, 32'hB1);
    chk("t6 fs after", {31'd0, frame_start}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
